// File: rtl/udt_pkt_encode.sv
// udt_pkt_encode: transmit-side UDT data-packet framer.
// Accepts a message command (length in 32-bit words) and a payload word stream.
// Each message is cut into packets of at most MSS_WORDS payload words. Every
// packet starts with four header words: sequence number, FF/O/message number,
// timestamp and destination socket ID.
// The block keeps the 31-bit packet sequence number, the 29-bit message number
// and a free-running microsecond timestamp.
module udt_pkt_encode #(
   parameter int unsigned MSS_WORDS  = 366,
   parameter int unsigned CLK_PER_US = 200,
   parameter logic [30:0] INIT_SEQ   = 31'd0,
   parameter logic [28:0] INIT_MSGNO = 29'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] cfg_dst_sock_id,
   input  logic [30:0] cfg_isn,
   input  logic        cfg_isn_load,
   input  logic        cfg_in_order,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_len,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [31:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic [30:0] cur_seq,
   output logic [28:0] cur_msgno,
   output logic        err_len
);

   localparam logic [31:0]      MSS32   = 32'(MSS_WORDS);
   localparam int               DIV_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_PER_US - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_PAYLOAD
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      rem_q, rem_d;        // payload words left in the message
   logic [15:0]      pcnt_q, pcnt_d;      // payload words left in the packet
   logic             first_q, first_d;    // current packet is the first fragment
   logic [1:0]       hidx_q, hidx_d;      // header word index
   logic [30:0]      seq_q, seq_d;
   logic [28:0]      msgno_q, msgno_d;
   logic [31:0]      tslat_q, tslat_d;    // timestamp captured on entry to HDR
   logic             err_q, err_d;
   logic [31:0]      mdata_q, mdata_d;
   logic             mvalid_q, mvalid_d;
   logic             mlast_q, mlast_d;
   logic [31:0]      ts_q;
   logic [DIV_W-1:0] div_q;
   logic             run_q;               // low while in reset, high from the first clock after

   logic             adv;
   logic             last_frag;
   logic [15:0]      plen;
   logic             cmd_fire;

   // The output register may take a new word when it is empty or being drained.
   assign adv       = !mvalid_q || m_ready;
   // Remaining message fits in one packet: this is the final fragment.
   assign last_frag = ({16'd0, rem_q} <= MSS32);
   assign plen      = last_frag ? rem_q : MSS32[15:0];

   assign m_data    = mdata_q;
   assign m_valid   = mvalid_q;
   assign m_last    = mlast_q;
   assign cur_seq   = seq_q;
   assign cur_msgno = msgno_q;
   assign err_len   = err_q;

   // Next-state, header/payload muxing and handshake generation.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      pcnt_d    = pcnt_q;
      first_d   = first_q;
      hidx_d    = hidx_q;
      seq_d     = seq_q;
      msgno_d   = msgno_q;
      tslat_d   = tslat_q;
      err_d     = err_q;
      mdata_d   = mdata_q;
      mvalid_d  = mvalid_q;
      mlast_d   = mlast_q;
      cmd_ready = 1'b0;
      s_ready   = 1'b0;
      cmd_fire  = 1'b0;

      // A word leaving the output register empties it unless replaced below.
      if (adv) begin
         mvalid_d = 1'b0;
         mlast_d  = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            // A sequence-number load takes priority; the command waits a cycle.
            cmd_ready = run_q && !cfg_isn_load;
            cmd_fire  = cmd_valid && cmd_ready;
            if (run_q && cfg_isn_load) begin
               seq_d = cfg_isn;
            end else if (cmd_fire) begin
               if (cmd_len == 16'd0) begin
                  err_d = 1'b1;
               end else begin
                  rem_d   = cmd_len;
                  first_d = 1'b1;
                  hidx_d  = 2'd0;
                  tslat_d = ts_q;
                  state_d = S_HDR;
               end
            end
         end

         S_HDR: begin
            // Header words go out back to back, independent of s_valid.
            if (adv) begin
               mvalid_d = 1'b1;
               mlast_d  = 1'b0;
               case (hidx_q)
                  2'd0:    mdata_d = {1'b0, seq_q};
                  2'd1:    mdata_d = {first_q, last_frag, cfg_in_order, msgno_q};
                  2'd2:    mdata_d = tslat_q;
                  default: mdata_d = cfg_dst_sock_id;
               endcase
               hidx_d = hidx_q + 2'd1;
               if (hidx_q == 2'd3) begin
                  pcnt_d  = plen;
                  state_d = S_PAYLOAD;
               end
            end
         end

         S_PAYLOAD: begin
            // Payload passes straight through the output register, one cycle late.
            s_ready = adv;
            if (s_valid && adv) begin
               mvalid_d = 1'b1;
               mdata_d  = s_data;
               rem_d    = rem_q - 16'd1;
               pcnt_d   = pcnt_q - 16'd1;
               if (pcnt_q == 16'd1) begin
                  mlast_d = 1'b1;
                  seq_d   = seq_q + 31'd1;
                  if (rem_q == 16'd1) begin
                     msgno_d = msgno_q + 29'd1;
                     state_d = S_IDLE;
                  end else begin
                     first_d = 1'b0;
                     hidx_d  = 2'd0;
                     tslat_d = ts_q;
                     state_d = S_HDR;
                  end
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Framer state, counters and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rem_q    <= 16'd0;
         pcnt_q   <= 16'd0;
         first_q  <= 1'b0;
         hidx_q   <= 2'd0;
         seq_q    <= INIT_SEQ;
         msgno_q  <= INIT_MSGNO;
         tslat_q  <= 32'd0;
         err_q    <= 1'b0;
         mdata_q  <= 32'd0;
         mvalid_q <= 1'b0;
         mlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         pcnt_q   <= pcnt_d;
         first_q  <= first_d;
         hidx_q   <= hidx_d;
         seq_q    <= seq_d;
         msgno_q  <= msgno_d;
         tslat_q  <= tslat_d;
         err_q    <= err_d;
         mdata_q  <= mdata_d;
         mvalid_q <= mvalid_d;
         mlast_q  <= mlast_d;
      end
   end

   // Microsecond timestamp: prescaler of CLK_PER_US cycles, 32-bit wrapping count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         ts_q  <= 32'd0;
      end else if (div_q == DIV_MAX) begin
         div_q <= '0;
         ts_q  <= ts_q + 32'd1;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   // Keeps cmd_ready low while reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

endmodule
